// File: rtl/branch_cmp_serial.sv
// Multi-cycle MSB-first branch comparator for the stage-2 branch path.
// Scans CHUNK bits per cycle, stops at the first differing slice.
module branch_cmp_serial #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rs1d,
  input  logic [WIDTH-1:0] rs2d,
  input  logic [2:0]       funct3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eq,
  output logic             lt,
  output logic             taken,
  output logic             illegal,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a, b;
  logic [2:0]       f3;
  logic [IW-1:0]    idx;
  logic [CHUNK-1:0] sa, sb;
  logic             diff, scan_end, sgn;

  // Operands shift up one slice per cycle; the top slice is always compared.
  assign sa       = a[WIDTH-1 -: CHUNK];
  assign sb       = b[WIDTH-1 -: CHUNK];
  assign diff     = (sa != sb);
  assign scan_end = diff || (idx == '0);
  assign sgn      = (funct3[2:1] == 2'b10);

  function automatic logic decode(
    input logic [2:0] f,
    input logic       e,
    input logic       l
  );
    logic r;
    r = 1'b0;
    case (f)
      3'b000:         r = e;
      3'b001:         r = !e;
      3'b100, 3'b110: r = l;
      3'b101, 3'b111: r = !l;
      default:        r = 1'b0;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid) state_nx = SCAN;
      SCAN:    if (scan_end) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a       <= '0;
      b       <= '0;
      f3      <= '0;
      idx     <= '0;
      eq      <= 1'b0;
      lt      <= 1'b0;
      taken   <= 1'b0;
      illegal <= 1'b0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        // Flipping the sign bit maps signed order onto unsigned order.
        a   <= rs1d ^ (sgn ? MSB : '0);
        b   <= rs2d ^ (sgn ? MSB : '0);
        f3  <= funct3;
        idx <= LAST;
      end
    end else if (state == SCAN) begin
      if (scan_end) begin
        eq      <= !diff;
        lt      <= diff && (sa < sb);
        taken   <= decode(f3, !diff, diff && (sa < sb));
        illegal <= (f3[2:1] == 2'b01);
      end else begin
        a   <= a << CHUNK;
        b   <= b << CHUNK;
        idx <= idx - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_cmp_serial.sv
// Directed and randomized checks of branch_cmp_serial
// at CHUNK = 8, 32 and 1 sharing one stimulus stream.
module tb_branch_cmp_serial;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] rs1d, rs2d;
  logic [2:0]  funct3;
  logic [2:0]  ir, ov, eqo, lto, tko, ilo, bs;

  int ntest = 0;
  int nfail = 0;
  int lat[3];
  int csz[3] = '{8, 32, 1};
  logic [31:0] ca, cb;
  logic [2:0]  cf;

  always #5 clk = ~clk;

  branch_cmp_serial #(.WIDTH(32), .CHUNK(8)) u8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]),
    .rs1d(rs1d), .rs2d(rs2d), .funct3(funct3), .out_valid(ov[0]),
    .out_ready(out_ready), .eq(eqo[0]), .lt(lto[0]), .taken(tko[0]),
    .illegal(ilo[0]), .busy(bs[0])
  );

  branch_cmp_serial #(.WIDTH(32), .CHUNK(32)) u32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]),
    .rs1d(rs1d), .rs2d(rs2d), .funct3(funct3), .out_valid(ov[1]),
    .out_ready(out_ready), .eq(eqo[1]), .lt(lto[1]), .taken(tko[1]),
    .illegal(ilo[1]), .busy(bs[1])
  );

  branch_cmp_serial #(.WIDTH(32), .CHUNK(1)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[2]),
    .rs1d(rs1d), .rs2d(rs2d), .funct3(funct3), .out_valid(ov[2]),
    .out_ready(out_ready), .eq(eqo[2]), .lt(lto[2]), .taken(tko[2]),
    .illegal(ilo[2]), .busy(bs[2])
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    ntest++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input logic [31:0] d, input int c);
    int h;
    h = -1;
    for (int i = 0; i < 32; i++) if (d[i]) h = i;
    if (h < 0) return 32 / c;
    return (32 / c) - (h / c);
  endfunction

  task automatic start(input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] f);
    @(negedge clk);
    ca = a; cb = b; cf = f;
    rs1d = a; rs2d = b; funct3 = f; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rs1d = $urandom; rs2d = $urandom; funct3 = 3'($urandom);
  endtask

  task automatic wait_done();
    lat = '{0, 0, 0};
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) if (ov[i] && lat[i] == 0) lat[i] = c;
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) return;
    end
    chk("timeout", 0, 1);
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("cons_rdy", 32'(ir), 32'h7);
    chk("cons_ov", 32'(ov), 32'h0);
  endtask

  task automatic mdl_chk(input string tag);
    logic e, l, t, il;
    e  = (ca == cb);
    l  = (cf[2:1] == 2'b10) ? ($signed(ca) < $signed(cb)) : (ca < cb);
    il = (cf == 3'b010) || (cf == 3'b011);
    case (cf)
      3'b000:  t = e;
      3'b001:  t = !e;
      3'b100:  t = l;
      3'b110:  t = l;
      3'b101:  t = !l;
      3'b111:  t = !l;
      default: t = 1'b0;
    endcase
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_c%0d_eq", tag, csz[i]), 32'(eqo[i]), 32'(e));
      chk($sformatf("%s_c%0d_lt", tag, csz[i]), 32'(lto[i]), 32'(l));
      chk($sformatf("%s_c%0d_tk", tag, csz[i]), 32'(tko[i]), 32'(t));
      chk($sformatf("%s_c%0d_il", tag, csz[i]), 32'(ilo[i]), 32'(il));
      chk($sformatf("%s_c%0d_lat", tag, csz[i]), 32'(lat[i]),
          32'(exp_lat(ca ^ cb, csz[i])));
    end
  endtask

  task automatic dir(input string tag, input logic [31:0] a,
                     input logic [31:0] b, input logic [2:0] f,
                     input logic e_eq, input logic e_lt, input logic e_tk,
                     input logic e_il, input int e_lat);
    start(a, b, f);
    wait_done();
    chk({tag, "_eq"}, 32'(eqo[0]), 32'(e_eq));
    chk({tag, "_lt"}, 32'(lto[0]), 32'(e_lt));
    chk({tag, "_tk"}, 32'(tko[0]), 32'(e_tk));
    chk({tag, "_il"}, 32'(ilo[0]), 32'(e_il));
    chk({tag, "_lat"}, 32'(lat[0]), 32'(e_lat));
    chk({tag, "_lat32"}, 32'(lat[1]), 32'd1);
    consume();
  endtask

  initial begin
    logic [31:0] a, b, m;
    logic [2:0]  snap_eq, snap_tk;
    int sh;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    rs1d = '0; rs2d = '0; funct3 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", 32'(ir), 32'h7);
    chk("rst_ov", 32'(ov), 32'h0);
    chk("rst_busy", 32'(bs), 32'h0);
    chk("rst_res", {20'h0, eqo, lto, tko, ilo}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    dir("beq_eq",   32'h1234_5678, 32'h1234_5678, 3'b000, 1, 0, 1, 0, 4);
    dir("blt_neg",  32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 0, 1, 1, 0, 1);
    dir("bltu_big", 32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 0, 0, 0, 0, 1);
    dir("bge_neg",  32'hFFFF_FFFF, 32'h0000_0001, 3'b101, 0, 1, 0, 0, 1);
    dir("bgeu_lo",  32'h0000_0100, 32'h0000_0101, 3'b111, 0, 1, 0, 0, 4);
    dir("bne_lo",   32'h0000_0100, 32'h0000_0101, 3'b001, 0, 1, 1, 0, 4);
    dir("blt_min",  32'h8000_0000, 32'h7FFF_FFFF, 3'b100, 0, 1, 1, 0, 1);
    dir("ill_011",  32'h0000_0005, 32'h0000_0003, 3'b011, 0, 0, 0, 1, 4);
    dir("ill_010",  32'h0000_0003, 32'h0000_0005, 3'b010, 0, 1, 0, 1, 4);

    // Backpressure: results hold, new requests are refused.
    start(32'h0000_0100, 32'h0000_0101, 3'b001);
    wait_done();
    snap_eq = eqo; snap_tk = tko;
    @(negedge clk);
    in_valid = 1'b1; rs1d = 32'h1; rs2d = 32'h1; funct3 = 3'b000;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("bp_ov", 32'(ov), 32'h7);
      chk("bp_rdy", 32'(ir), 32'h0);
      chk("bp_busy", 32'(bs), 32'h7);
      chk("bp_eq", 32'(eqo), 32'(snap_eq));
      chk("bp_tk", 32'(tko), 32'(snap_tk));
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_idle_rdy", 32'(ir), 32'h7);
    chk("bp_idle_ov", 32'(ov), 32'h0);
    chk("bp_keep_tk", 32'(tko), 32'h7);
    chk("bp_keep_eq", 32'(eqo), 32'h0);

    // Reset during the second scan cycle of an equal-operand request.
    start(32'hA5A5_A5A5, 32'hA5A5_A5A5, 3'b000);
    @(posedge clk); #1;
    chk("mid_busy8", 32'(bs[0]), 32'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_rdy", 32'(ir), 32'h7);
    chk("mid_rst_ov", 32'(ov), 32'h0);
    chk("mid_rst_busy", 32'(bs), 32'h0);
    chk("mid_rst_eq", 32'(eqo), 32'h0);
    dir("post_rst", 32'h0000_0010, 32'h0000_0020, 3'b110, 0, 1, 1, 0, 4);

    for (int n = 0; n < 1000; n++) begin
      a  = $urandom;
      sh = $urandom_range(0, 32);
      m  = (sh == 32) ? 32'h0 : ($urandom >> sh);
      b  = (n % 10 == 0) ? $urandom : (a ^ m);
      start(a, b, 3'($urandom));
      wait_done();
      mdl_chk("rnd");
      consume();
    end

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule

// File: doc/branch_cmp_serial.md
# branch_cmp_serial

Parametrised, multi-cycle branch-condition unit for the stage-2 branch path. Accepts two operands and a RISC-V branch funct3 over a valid/ready handshake, then compares them MSB-first one CHUNK-bit slice per cycle, stopping at the first differing slice. Reports eq, lt, the resolved taken bit and an illegal-funct3 flag. It generalises the single-cycle signed/unsigned comparator to any width, trading latency for area, and adds full funct3 decode and handshaking.

## Interface
- WIDTH, 32: operand width in bits.
- CHUNK, 8: bits compared per cycle; WIDTH % CHUNK == 0 and CHUNK >= 1 required. NCHUNK = WIDTH/CHUNK.
- clk  input  1  sole clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request; high only in IDLE.
- rs1d  input  WIDTH  operand A.
- rs2d  input  WIDTH  operand B.
- funct3  input  3  branch type: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU; 010/011 illegal.
- out_valid  output  1  result valid; held until consumed.
- out_ready  input  1  consumer accepts result.
- eq  output  1  A == B.
- lt  output  1  A < B (signed for 100/101, unsigned otherwise).
- taken  output  1  branch taken.
- illegal  output  1  funct3 was 010 or 011.
- busy  output  1  high in SCAN or DONE.

## Operation
- States: IDLE, SCAN, DONE. Reset value: IDLE; in_ready=1; out_valid, eq, lt, taken, illegal, busy all 0; slice index 0.
- IDLE: in_ready=1. On in_valid && in_ready: register rs1d, rs2d, funct3; if funct3[2:1]==2'b10 (signed), invert bit WIDTH-1 of both registered operands so one unsigned compare serves both modes. Set index = NCHUNK-1; go SCAN.
- SCAN, per cycle, slice k = bits [k*CHUNK+CHUNK-1 : k*CHUNK]:
  - slices differ: eq=0, lt=(A slice < B slice, unsigned); go DONE.
  - slices equal and k==0: eq=1, lt=0; go DONE.
  - slices equal and k>0: k=k-1; stay SCAN.
- taken decode: 000 eq; 001 !eq; 100/110 lt; 101/111 !lt; 010/011 taken=0, illegal=1. eq and lt are still computed for illegal codes.
- DONE: out_valid=1; eq, lt, taken, illegal stable. On out_ready: out_valid=0; go IDLE. No new request is accepted in the same cycle as result consumption.
- eq/lt/taken/illegal retain their last values after consumption until the next result; they are qualified only by out_valid.
- Inputs rs1d/rs2d/funct3 are ignored outside the accept cycle.
- reset in any state, including mid-SCAN or DONE with out_ready low: next cycle IDLE with reset values; the in-flight request is discarded and no out_valid pulse is produced.

## Timing
- Accept at edge E0. If the first differing slice is the m-th examined (m = 1..NCHUNK), or m = NCHUNK when the operands are equal, out_valid is high in the cycle after edge E0+m, i.e. m cycles after accept.
- CHUNK == WIDTH: fixed latency 1.
- Throughput: at most one request per m+2 cycles (accept, m scan cycles, consume, then IDLE).
- out_ready is sampled only in DONE. out_ready held high gives a 1-cycle DONE.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

## Test plan
- WIDTH=32, CHUNK=8, rs1d=rs2d=32'h1234_5678, BEQ -> out_valid 4 cycles after accept, eq=1, lt=0, taken=1.
- rs1d=32'hFFFF_FFFF, rs2d=32'h0000_0001, BLT -> latency 1, lt=1, taken=1. Same operands with BLTU -> lt=0, taken=0. Same operands with BGE -> taken=0.
- rs1d=32'h0000_0100, rs2d=32'h0000_0101, BGEU -> latency 4, eq=0, lt=1, taken=0. BNE on the same operands -> taken=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> outputs stable, in_ready=0, busy=1. A new in_valid during this time is not accepted. Raise out_ready -> IDLE next cycle, in_ready=1.
- Assert reset during the 2nd SCAN cycle -> next cycle IDLE, out_valid=0, busy=0. A fresh request then completes correctly.
- funct3=3'b011 with unequal operands -> illegal=1, taken=0. Repeat with CHUNK=32 and CHUNK=1 (WIDTH=32) -> latencies 1 and 1..32 respectively, matching a golden model over 1000 random requests.
